// File: rtl/reminder_scheduler_if.sv
// rtl/reminder_scheduler_if.sv - tick/level/ack inputs and reminder outputs of the scheduler
interface reminder_scheduler_if;
  logic       tick;
  logic [3:0] water_level;
  logic       ack;
  logic       remind;
  logic       remind_pulse;
  logic       snoozing;
  logic [2:0] miss_count;

  // Driver side: time base, sensor and button; receives the LED/buzzer controls
  modport master (
    output tick, water_level, ack,
    input  remind, remind_pulse, snoozing, miss_count
  );

  // Scheduler side
  modport slave (
    input  tick, water_level, ack,
    output remind, remind_pulse, snoozing, miss_count
  );
endinterface

// File: rtl/reminder_scheduler.sv
// rtl/reminder_scheduler.sv - drink-interval countdown, alert/snooze sequencing, miss tracking (optional REMINDER_ESCALATE_EN)
module reminder_scheduler #(
  parameter int INTERVAL   = 900,
  parameter int SNOOZE_LEN = 300,
  parameter int ALERT_LEN  = 60
) (
  input logic                 clk,
  input logic                 reset_n,
  reminder_scheduler_if.slave bus
);

  localparam int MAX_A = (INTERVAL > SNOOZE_LEN) ? INTERVAL : SNOOZE_LEN;
  localparam int MAX_L = (MAX_A > ALERT_LEN) ? MAX_A : ALERT_LEN;
  localparam int CW    = $clog2(MAX_L + 1);

  localparam logic [CW-1:0] INT_C    = CW'(INTERVAL);
  localparam logic [CW-1:0] SNOOZE_C = CW'(SNOOZE_LEN);
  localparam logic [CW-1:0] ALERT_C  = CW'(ALERT_LEN);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  localparam logic [1:0] ST_DONE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ALERT  = 2'd2;
  localparam logic [1:0] ST_SNOOZE = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [3:0]    lvl_d1;
  logic [3:0]    lvl_d2;
  logic [2:0]    miss_count;
  logic          remind_pulse;

  logic          drink;
  logic          empty;
  logic [2:0]    miss_inc;
  logic [CW-1:0] reload_keep;
  logic [CW-1:0] reload_miss;

  assign drink    = (lvl_d2 > lvl_d1);
  assign empty    = (lvl_d1 == 4'd0);
  assign miss_inc = (miss_count == 3'd7) ? 3'd7 : miss_count + 3'd1;

`ifdef REMINDER_ESCALATE_EN
  // Escalated reload shortens the interval by the miss count, never below one tick
  always_comb begin
    reload_keep = INT_C >> miss_count;
    reload_miss = INT_C >> miss_inc;
    if (reload_keep == '0) reload_keep = ONE_C;
    if (reload_miss == '0) reload_miss = ONE_C;
  end
`else
  assign reload_keep = INT_C;
  assign reload_miss = INT_C;
`endif

  // Level pipeline plus the scheduler FSM; drink beats empty beats ack beats expiry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_DONE;
      cnt          <= '0;
      lvl_d1       <= 4'd0;
      lvl_d2       <= 4'd0;
      miss_count   <= 3'd0;
      remind_pulse <= 1'b0;
    end else begin
      lvl_d1       <= bus.water_level;
      lvl_d2       <= lvl_d1;
      remind_pulse <= 1'b0;
      if (state != ST_DONE && drink) begin
        state      <= ST_WAIT;
        miss_count <= 3'd0;
        cnt        <= INT_C;
      end else if (state != ST_DONE && empty) begin
        state <= ST_DONE;
      end else begin
        case (state)
          ST_DONE: begin
            if (!empty) begin
              state <= ST_WAIT;
              cnt   <= reload_keep;
            end
          end
          ST_WAIT, ST_SNOOZE: begin
            if (bus.tick) begin
              if (cnt == ONE_C) begin
                state        <= ST_ALERT;
                cnt          <= ALERT_C;
                remind_pulse <= 1'b1;
              end else begin
                cnt <= cnt - ONE_C;
              end
            end
          end
          ST_ALERT: begin
            if (bus.ack) begin
              state <= ST_SNOOZE;
              cnt   <= SNOOZE_C;
            end else if (bus.tick) begin
              if (cnt == ONE_C) begin
                miss_count <= miss_inc;
                state      <= ST_WAIT;
                cnt        <= reload_miss;
              end else begin
                cnt <= cnt - ONE_C;
              end
            end
          end
          default: state <= ST_DONE;
        endcase
      end
    end
  end

  assign bus.remind       = (state == ST_ALERT);
  assign bus.snoozing     = (state == ST_SNOOZE);
  assign bus.miss_count   = miss_count;
  assign bus.remind_pulse = remind_pulse;

endmodule

// File: tb/tb_reminder_scheduler.sv
// tb/tb_reminder_scheduler.sv - directed self-checking bench for reminder_scheduler
module tb_reminder_scheduler;
  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_err = 0;

`ifdef REMINDER_ESCALATE_EN
  localparam bit ESC = 1'b1;
`else
  localparam bit ESC = 1'b0;
`endif

  reminder_scheduler_if bus();

  reminder_scheduler #(.INTERVAL(4), .SNOOZE_LEN(2), .ALERT_LEN(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // three idle cycles, then one tick cycle; returns just after the tick edge
  task automatic tk();
    bus.tick = 1'b0;
    cyc(3);
    bus.tick = 1'b1;
    cyc(1);
    bus.tick = 1'b0;
  endtask

  function automatic int exp_int(input int m);
    int v;
    v = 4 >> m;
    if (v < 1) v = 1;
    return ESC ? v : 4;
  endfunction

  // advance to the next alert, checking it arrives on exactly the n-th tick
  task automatic wait_alert(input string tag, input int n);
    for (int i = 1; i < n; i++) begin
      tk();
      check({tag, "_early"}, 8'(bus.remind), 8'd0);
    end
    tk();
    check({tag, "_remind"}, 8'(bus.remind), 8'd1);
    check({tag, "_pulse"}, 8'(bus.remind_pulse), 8'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n         = 1'b0;
    bus.tick        = 1'b0;
    bus.water_level = 4'd0;
    bus.ack         = 1'b0;
    #2;
    check("rst_remind", 8'(bus.remind), 8'd0);
    check("rst_pulse", 8'(bus.remind_pulse), 8'd0);
    check("rst_snooze", 8'(bus.snoozing), 8'd0);
    check("rst_miss", 8'(bus.miss_count), 8'd0);
    cyc(2);
    bus.water_level = 4'd8;
    reset_n = 1'b1;
    cyc(2);

    // first alert after 4 ticks
    wait_alert("first", 4);
    check("first_miss", 8'(bus.miss_count), 8'd0);
    cyc(1);
    check("first_pulse_drop", 8'(bus.remind_pulse), 8'd0);
    check("first_remind_hold", 8'(bus.remind), 8'd1);

    // ack into snooze, re-alert after 2 ticks
    bus.ack = 1'b1;
    cyc(1);
    bus.ack = 1'b0;
    check("ack_remind", 8'(bus.remind), 8'd0);
    check("ack_snooze", 8'(bus.snoozing), 8'd1);
    tk();
    check("snooze_mid", 8'(bus.snoozing), 8'd1);
    tk();
    check("resnooze_remind", 8'(bus.remind), 8'd1);
    check("resnooze_pulse", 8'(bus.remind_pulse), 8'd1);
    check("resnooze_snooze", 8'(bus.snoozing), 8'd0);

    // eight unacknowledged alerts; miss_count saturates at 7
    for (int k = 1; k <= 8; k++) begin
      tk();
      tk();
      check("miss_hold", 8'(bus.remind), 8'd1);
      tk();
      check("miss_remind", 8'(bus.remind), 8'd0);
      check("miss_count", 8'(bus.miss_count), 8'((k > 7) ? 7 : k));
      wait_alert("miss_next", exp_int((k > 7) ? 7 : k));
    end

    // drink in ALERT with ack on the detection edge: drink wins
    bus.water_level = 4'd7;
    cyc(1);
    check("drink_edge1", 8'(bus.remind), 8'd1);
    bus.ack = 1'b1;
    cyc(1);
    bus.ack = 1'b0;
    check("drink_remind", 8'(bus.remind), 8'd0);
    check("drink_snooze", 8'(bus.snoozing), 8'd0);
    check("drink_miss", 8'(bus.miss_count), 8'd0);
    wait_alert("drink_next", 4);

    // drink coinciding with a tick: the tick is not counted
    bus.water_level = 4'd6;
    cyc(1);
    bus.tick = 1'b1;
    cyc(1);
    bus.tick = 1'b0;
    check("drinktick_remind", 8'(bus.remind), 8'd0);
    wait_alert("drinktick_next", 4);

    // empty bottle goes quiet
    bus.water_level = 4'd0;
    cyc(3);
    for (int i = 0; i < 20; i++) begin
      tk();
      check("empty_quiet", 8'(bus.remind | bus.snoozing), 8'd0);
    end

    // refill is not a drink, alert after full interval
    bus.water_level = 4'd15;
    wait_alert("refill", 4);

    // build a miss, then reset mid-ALERT
    tk();
    tk();
    tk();
    check("pre_rst_miss", 8'(bus.miss_count), 8'd1);
    wait_alert("pre_rst", exp_int(1));
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_remind", 8'(bus.remind), 8'd0);
    check("arst_pulse", 8'(bus.remind_pulse), 8'd0);
    check("arst_snooze", 8'(bus.snoozing), 8'd0);
    check("arst_miss", 8'(bus.miss_count), 8'd0);
    bus.water_level = 4'd5;
    cyc(1);
    reset_n = 1'b1;
    cyc(2);
    wait_alert("post_rst", 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
